// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS general-purpose register file.
// Default geometry is 32 entries of 32 bits; entry ZERO_REG always reads zero.
package mips_pkg;

    localparam int REG_DW    = 32;
    localparam int REG_DEPTH = 32;
    localparam int REG_AW    = 5;
    localparam int ZERO_REG  = 0;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer for the register file: sweeps every entry to zero after
// reset or on a clear request, and reports busy while the sweep runs.
module regfile_clear_seq
    import mips_pkg::*;
#(
    parameter int DEPTH = REG_DEPTH,
    parameter int AW    = REG_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          busy
);

    // One extra counter bit keeps the terminal count distinct from a wrap to zero.
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    rf_state_t   state;
    logic [AW:0] clr_cnt;

    // Sweep FSM: CLEAR walks clr_cnt over all entries, READY waits for a clear request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == LAST) begin
                        state   <= READY;
                        busy    <= 1'b0;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                READY: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // No sweep write happens on a reset edge; the sweep restarts afterwards.
    assign clr_we   = (state == CLEAR) && rst_n;
    assign clr_addr = clr_cnt[AW-1:0];

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with synchronous clear sweep and busy status.
// Entry 0 always reads as zero; writes are ignored while the sweep runs.
// Optional feature macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_mp
    import mips_pkg::*;
#(
    parameter int DW     = REG_DW,
    parameter int DEPTH  = REG_DEPTH,
    parameter int AW     = REG_AW,
    parameter int NUM_RD = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_req,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DW-1:0]        wdata,
    input  logic [NUM_RD*AW-1:0] raddr,
    output logic [NUM_RD*DW-1:0] rdata,
    output logic                 busy
);

    logic [DW-1:0] mem [DEPTH];
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          port_we;

    regfile_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy)
    );

    // A port write only lands when idle, out of reset, and not aimed at entry 0.
    assign port_we = rst_n && !busy && we && (waddr != AW'(ZERO_REG));

    // Storage update: the clear sweep and the write port are mutually exclusive via busy.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (port_we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;

        assign ra = raddr[i*AW +: AW];

        // Combinational read: zero for entry 0 or while clearing, optional forwarding.
        always_comb begin
            rd = mem[ra];
            if (busy || ra == AW'(ZERO_REG)) begin
                rd = '0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (we && waddr != AW'(ZERO_REG) && waddr == ra) begin
                rd = wdata;
            end
`endif
        end

        assign rdata[i*DW +: DW] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_regfile_mp;

    localparam int DW     = 32;
    localparam int DEPTH  = 32;
    localparam int AW     = 5;
    localparam int NUM_RD = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clr_req;
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [DW-1:0]        wdata;
    logic [NUM_RD*AW-1:0] raddr;
    logic [NUM_RD*DW-1:0] rdata;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp #(
        .DW     (DW),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   (raddr),
        .rdata   (rdata),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: contents, and number of clock edges still needed to finish clearing.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left  = DEPTH;
    bit            started = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = DEPTH;
            for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end else begin
            if (we && waddr != 0) m_mem[waddr] = wdata;
            if (clr_req) begin
                m_left = DEPTH;
                for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
            end
        end
        started = 1'b1;
    end

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (m_left > 0 || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr != 0 && waddr == a) return wdata;
`endif
        return m_mem[a];
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            check("busy", DW'(busy), DW'(m_left > 0));
            for (int p = 0; p < NUM_RD; p++)
                check($sformatf("rdata%0d", p), rdata[p*DW +: DW], model_rd(raddr[p*AW +: AW]));
        end
    end

    // Advance one cycle; inputs change just after the negedge compare.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    // Counts clock edges until busy drops, bounded so a stuck busy still ends the run.
    task automatic count_busy(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (busy && n < 200);
    endtask

    int n;
    logic [DW-1:0] exp4;

    initial begin
        rst_n = 1'b0; clr_req = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;

        // Reset held for two cycles, then the 32-cycle initial sweep.
        cyc(); cyc();
        check("reset_busy", DW'(busy), 32'd1);
        check("reset_rdata0", rdata[0 +: DW], 32'd0);
        rst_n = 1'b1;
        count_busy(n);
        check("init_clear_len", DW'(n), 32'd32);

        // Plain write then read on the next cycle.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; set_rd(5'd5, 5'd0);
        cyc();
        we = 1'b0;
        #1;
        check("wr5_rd0", rdata[0 +: DW], 32'hDEADBEEF);
        check("wr5_rd1_zero", rdata[DW +: DW], 32'd0);

        // Writes to entry 0 are dropped.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; set_rd(5'd0, 5'd0);
        cyc();
        we = 1'b0;
        #1;
        check("zero_rd0", rdata[0 +: DW], 32'd0);
        check("zero_rd1", rdata[DW +: DW], 32'd0);

        // Same-cycle write and read of entry 7.
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; set_rd(5'd7, 5'd5);
        #1;
`ifdef REGFILE_BYPASS_EN
        exp4 = 32'h12345678;
`else
        exp4 = 32'd0;
`endif
        check("same_cycle_rd7", rdata[0 +: DW], exp4);
        cyc();
        we = 1'b0;
        #1;
        check("next_cycle_rd7", rdata[0 +: DW], 32'h12345678);

        // Clear request: write during the sweep is dropped, reg 3 ends at zero.
        we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5; set_rd(5'd3, 5'd7);
        cyc();
        we = 1'b0;
        #1;
        check("fill_rd3", rdata[0 +: DW], 32'hA5A5A5A5);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        check("clr_busy", DW'(busy), 32'd1);
        we = 1'b1; waddr = 5'd3; wdata = 32'h11111111;
        count_busy(n);
        we = 1'b0;
        check("clr_len", DW'(n), 32'd32);
        #1;
        check("after_clr_rd3", rdata[0 +: DW], 32'd0);
        check("after_clr_rd7", rdata[DW +: DW], 32'd0);

        // Reset pulsed in the middle of a sweep restarts it.
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        repeat (9) cyc();
        rst_n = 1'b0;
        cyc(); cyc();
        check("midclr_reset_busy", DW'(busy), 32'd1);
        rst_n = 1'b1;
        count_busy(n);
        check("restart_clear_len", DW'(n), 32'd32);

        // Randomized traffic checked each cycle by the compare process.
        for (int i = 0; i < 1500; i++) begin
            we      = ($urandom_range(0, 3) != 0);
            waddr   = AW'($urandom_range(0, 7));
            wdata   = $urandom;
            raddr   = {AW'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 7))};
            clr_req = ($urandom_range(0, 199) == 0);
            rst_n   = ($urandom_range(0, 499) != 0);
            cyc();
        end
        rst_n = 1'b1; clr_req = 1'b0; we = 1'b0;
        repeat (40) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
